// File: rtl/operand_fetch.sv
// Register file and operand-fetch sequencer: eight general registers, one shared read port,
// two-cycle fetch of an A/B operand pair presented under valid/ready. Optional macro: WRITE_BYPASS_EN.
module operand_fetch #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [SEL_W-1:0]  writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    input  logic [SEL_W-1:0]  rnum_a,
    input  logic [SEL_W-1:0]  rnum_b,
    output logic              busy,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] ain,
    output logic [DATA_W-1:0] bin
);

    localparam int unsigned NREG = 2 ** SEL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              capture_c;
    logic              load_a_c;
    logic              load_b_c;
    logic [SEL_W-1:0]  idx_a;
    logic [SEL_W-1:0]  idx_b;
    logic [SEL_W-1:0]  rd_sel_c;
    logic [DATA_W-1:0] rd_data_c;
    logic [DATA_W-1:0] operand_c;
    logic [DATA_W-1:0] regs [NREG];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nx  = state;
        capture_c = 1'b0;
        load_a_c  = 1'b0;
        load_b_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture_c = 1'b1;
                    state_nx  = RD_A;
                end
            end
            RD_A: begin
                load_a_c = 1'b1;
                state_nx = RD_B;
            end
            RD_B: begin
                load_b_c = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                if (ready_in) begin
                    if (start) begin
                        capture_c = 1'b1;
                        state_nx  = RD_A;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Status flags track the state register one-for-one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            busy      <= (state_nx != IDLE);
            valid_out <= (state_nx == HOLD);
        end
    end

    // Shared read port: B index only while reading B
    always_comb begin
        rd_sel_c  = (state == RD_B) ? idx_b : idx_a;
        rd_data_c = regs[rd_sel_c];
`ifdef WRITE_BYPASS_EN
        operand_c = (write && (writenum == rd_sel_c)) ? data_in : rd_data_c;
`else
        operand_c = rd_data_c;
`endif
    end

    // Register file write port, independent of the sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            regs[writenum] <= data_in;
        end
    end

    // Index and operand latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_a <= '0;
            idx_b <= '0;
            ain   <= '0;
            bin   <= '0;
        end else begin
            if (capture_c) begin
                idx_a <= rnum_a;
                idx_b <= rnum_b;
            end
            if (load_a_c) begin
                ain <= operand_c;
            end
            if (load_b_c) begin
                bin <= operand_c;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch; expected values are hand-computed per step.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic        start;
    logic [2:0]  rnum_a;
    logic [2:0]  rnum_b;
    logic        busy;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] ain;
    logic [15:0] bin;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [15:0] rdw_exp_ain;

    operand_fetch #(.DATA_W(16), .SEL_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .start     (start),
        .rnum_a    (rnum_a),
        .rnum_b    (rnum_b),
        .busy      (busy),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .ain       (ain),
        .bin       (bin)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [15:0] val);
        write    = 1'b1;
        writenum = idx;
        data_in  = val;
        tick();
        write    = 1'b0;
    endtask

    initial begin
`ifdef WRITE_BYPASS_EN
        rdw_exp_ain = 16'h0002;
`else
        rdw_exp_ain = 16'h0001;
`endif
        rst_n = 1'b1; write = 1'b0; writenum = '0; data_in = '0;
        start = 1'b0; rnum_a = '0; rnum_b = '0; ready_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_valid", 16'(valid_out), 16'h0);
        chk("rst_ain", ain, 16'h0);
        chk("rst_bin", bin, 16'h0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset mid-RD_B
        wr(3'd3, 16'h1234);
        start = 1'b1; rnum_a = 3'd3; rnum_b = 3'd3;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_ain", ain, 16'h1234);
        chk("pre_rst_busy", 16'(busy), 16'h1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_valid", 16'(valid_out), 16'h0);
        chk("mid_rst_ain", ain, 16'h0);
        chk("mid_rst_bin", bin, 16'h0);
        rst_n = 1'b1;
        start = 1'b1; rnum_a = 3'd3; rnum_b = 3'd3;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("r3_cleared_valid", 16'(valid_out), 16'h1);
        chk("r3_cleared_ain", ain, 16'h0);
        chk("r3_cleared_bin", bin, 16'h0);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        chk("post_hs_valid", 16'(valid_out), 16'h0);
        chk("post_hs_busy", 16'(busy), 16'h0);

        // Basic fetch with exact latency
        wr(3'd1, 16'h00A5);
        wr(3'd2, 16'hF00F);
        start = 1'b1; rnum_a = 3'd1; rnum_b = 3'd2;
        tick();
        start = 1'b0;
        chk("e0_busy", 16'(busy), 16'h1);
        chk("e0_valid", 16'(valid_out), 16'h0);
        tick();
        chk("e1_valid", 16'(valid_out), 16'h0);
        chk("e1_ain", ain, 16'h00A5);
        tick();
        chk("e2_valid", 16'(valid_out), 16'h1);
        chk("e2_ain", ain, 16'h00A5);
        chk("e2_bin", bin, 16'hF00F);

        // Stall in HOLD while R1 is overwritten
        write = 1'b1; writenum = 3'd1; data_in = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            write = 1'b0;
            chk("stall_valid", 16'(valid_out), 16'h1);
            chk("stall_ain", ain, 16'h00A5);
        end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        chk("stall_rel_valid", 16'(valid_out), 16'h0);
        chk("stall_rel_busy", 16'(busy), 16'h0);

        // Back-to-back: restore R1, fetch, then restart from HOLD
        wr(3'd1, 16'h00A5);
        start = 1'b1; rnum_a = 3'd1; rnum_b = 3'd2;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("b2b_first_valid", 16'(valid_out), 16'h1);
        start = 1'b1; ready_in = 1'b1; rnum_a = 3'd2; rnum_b = 3'd1;
        tick();
        ready_in = 1'b0;
        rnum_a = 3'd5; rnum_b = 3'd5;
        chk("b2b_rda_valid", 16'(valid_out), 16'h0);
        chk("b2b_rda_busy", 16'(busy), 16'h1);
        tick();
        chk("b2b_rdb_valid", 16'(valid_out), 16'h0);
        chk("b2b_ain", ain, 16'hF00F);
        tick();
        chk("b2b_hold_valid", 16'(valid_out), 16'h1);
        chk("b2b_ain_hold", ain, 16'hF00F);
        chk("b2b_bin", bin, 16'h00A5);
        tick();
        start = 1'b0;
        chk("hold_start_nordy_valid", 16'(valid_out), 16'h1);
        chk("hold_start_nordy_ain", ain, 16'hF00F);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        chk("b2b_done_busy", 16'(busy), 16'h0);

        // Read-during-write in the RD_A cycle
        wr(3'd4, 16'h0001);
        start = 1'b1; rnum_a = 3'd4; rnum_b = 3'd4;
        tick();
        start = 1'b0;
        write = 1'b1; writenum = 3'd4; data_in = 16'h0002;
        tick();
        write = 1'b0;
        chk("rdw_ain", ain, rdw_exp_ain);
        tick();
        chk("rdw_valid", 16'(valid_out), 16'h1);
        chk("rdw_bin", bin, 16'h0002);
        chk("rdw_ain_hold", ain, rdw_exp_ain);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;

        // Same source register for A and B
        wr(3'd7, 16'h8001);
        start = 1'b1; rnum_a = 3'd7; rnum_b = 3'd7;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("same_valid", 16'(valid_out), 16'h1);
        chk("same_ain", ain, 16'h8001);
        chk("same_bin", bin, 16'h8001);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        chk("same_done_valid", 16'(valid_out), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
